// File: rtl/lsu.sv
// Load/store unit: validates one EXU memory op per handshake, runs a word-addressed
// req/ack bus transaction with byte strobes and formats load data for writeback.
module lsu #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] data_ram,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [0:0] {StIdle, StBus} state_e;

  localparam logic [7:0] WaitLimit = 8'(MAX_WAIT - 1);

  state_e      state;
  logic [7:0]  wait_cnt;
  logic [1:0]  off;
  logic [2:0]  funct3_q;

  logic        illegal;
  logic        misaligned;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] rdata_shift;
  logic [15:0] rdata_half;
  logic [31:0] ld_data;

  assign req_ready = (state == StIdle);

  // Accept-time decode of the incoming op.
  always_comb begin
    illegal    = req_we ? (req_funct3 > 3'd2)
                        : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    misaligned = 1'b0;
    st_wdata   = req_wdata;
    st_wstrb   = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin
        st_wdata = {4{req_wdata[7:0]}};
        st_wstrb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        misaligned = req_addr[0];
        st_wdata   = {2{req_wdata[15:0]}};
        st_wstrb   = 4'b0011 << {req_addr[1], 1'b0};
      end
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // Load formatting; funct3_q[2] set means zero-extend (LBU/LHU).
  always_comb begin
    rdata_shift = mem_rdata >> {off, 3'b000};
    rdata_half  = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q[1:0])
      2'b00:   ld_data = {{24{~funct3_q[2] & rdata_shift[7]}}, rdata_shift[7:0]};
      2'b01:   ld_data = {{16{~funct3_q[2] & rdata_half[15]}}, rdata_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      wait_cnt  <= '0;
      off       <= '0;
      funct3_q  <= '0;
      data_ram  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_cause <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        StIdle: begin
          if (req_valid) begin
            if (illegal) begin
              err       <= 1'b1;
              err_cause <= 2'b11;
            end else if (misaligned) begin
              err       <= 1'b1;
              err_cause <= 2'b01;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wstrb <= req_we ? st_wstrb : 4'b0000;
              mem_wdata <= st_wdata;
              off       <= req_addr[1:0];
              funct3_q  <= req_funct3;
              wait_cnt  <= '0;
              state     <= StBus;
            end
          end
        end
        StBus: begin
          // Ack takes priority over a timeout in the same cycle.
          if (mem_ack) begin
            mem_req <= 1'b0;
            done    <= 1'b1;
            state   <= StIdle;
            if (!mem_we) begin
              data_ram <= ld_data;
            end
          end else if (wait_cnt == WaitLimit) begin
            mem_req   <= 1'b0;
            err       <= 1'b1;
            err_cause <= 2'b10;
            state     <= StIdle;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: directed ops push expected completions into a queue and a
// monitor pops and checks each done/err pulse.
module tb_lsu;

  localparam int unsigned MaxWait = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] data_ram;
  logic        done;
  logic        err;
  logic [1:0]  err_cause;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic        is_err;
    logic [1:0]  cause;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_ram = 32'h0;

  lsu #(.MAX_WAIT(MaxWait)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .data_ram   (data_ram),
    .done       (done),
    .err        (err),
    .err_cause  (err_cause),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every completion pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done === 1'b1 && err === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL excl: done and err both high");
      end else if (done === 1'b1 || err === 1'b1) begin
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL stray: done=%b err=%b with nothing expected", done, err);
        end else begin
          e = sb_q.pop_front();
          if (err !== e.is_err || (e.is_err && err_cause !== e.cause) || data_ram !== e.data) begin
            errors++;
            $display("FAIL sb: got err=%b cause=%b data=%h, expected err=%b cause=%b data=%h",
                     err, err_cause, data_ram, e.is_err, e.cause, e.data);
          end
        end
      end
    end
  end

  // Issue one op; waits < 0 means never ack. Called at #1 after a rising edge.
  task automatic run_op(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int waits, input logic bus,
                        input logic [1:0] cause, input logic [31:0] exp_addr,
                        input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_ram);
    int cycles;
    logic timed_out;
    timed_out = bus && (waits < 0 || waits >= int'(MaxWait));
    if (!bus || timed_out) sb_q.push_back({1'b1, bus ? 2'b10 : cause, model_ram});
    else begin
      model_ram = exp_ram;
      sb_q.push_back({1'b0, 2'b00, model_ram});
    end
    check({name, ".ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!bus) begin
      check({name, ".noreq"}, 32'(mem_req), 32'd0);
      check({name, ".err"}, {30'd0, err, done}, 32'd2);
    end else begin
      check({name, ".addr"}, mem_addr, exp_addr);
      check({name, ".we"}, 32'(mem_we), 32'(we));
      check({name, ".wstrb"}, 32'(mem_wstrb), 32'(exp_wstrb));
      if (we) check({name, ".wdata"}, mem_wdata, exp_wdata);
      cycles = 0;
      while (mem_req === 1'b1 && cycles < 300) begin
        if (cycles == waits) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
        end
        cycles++;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'hxxxx_xxxx;
      end
      check({name, ".reqcyc"}, 32'(cycles), timed_out ? MaxWait : 32'(waits + 1));
      check({name, ".pulse"}, {30'd0, err, done}, timed_out ? 32'd2 : 32'd1);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.req", {29'd0, mem_req, done, err}, 32'd0);
    check("rst.ram", data_ram, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //     name   we  f3      addr          wdata         rdata        wt  bus cause addr        strb     wdata         ram
    run_op("lb",  0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 2, 1, 2'b00, 32'h1000, 4'b0000, 32'h0, 32'hFFFF_FF80);
    run_op("lbu", 0, 3'b100, 32'h0000_1003, 32'h0,        32'h80FF_1234, 2, 1, 2'b00, 32'h1000, 4'b0000, 32'h0, 32'h0000_0080);
    run_op("sh",  1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0,        0, 1, 2'b00, 32'h2000, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0080);
    run_op("sb",  1, 3'b000, 32'h0000_5001, 32'h0000_00A5, 32'h0,        1, 1, 2'b00, 32'h5000, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0080);
    run_op("lhu", 0, 3'b101, 32'h0000_6002, 32'h0,        32'h8001_7FFF, 0, 1, 2'b00, 32'h6000, 4'b0000, 32'h0, 32'h0000_8001);
    run_op("lh",  0, 3'b001, 32'h0000_6000, 32'h0,        32'h8001_8FFF, 3, 1, 2'b00, 32'h6000, 4'b0000, 32'h0, 32'hFFFF_8FFF);
    run_op("lwma",0, 3'b010, 32'h0000_3002, 32'h0,        32'h0,         0, 0, 2'b01, 32'h0,    4'b0000, 32'h0, 32'h0);
    run_op("lhma",0, 3'b001, 32'h0000_3001, 32'h0,        32'h0,         0, 0, 2'b01, 32'h0,    4'b0000, 32'h0, 32'h0);
    run_op("ldil",0, 3'b011, 32'h0000_3000, 32'h0,        32'h0,         0, 0, 2'b11, 32'h0,    4'b0000, 32'h0, 32'h0);
    run_op("stil",1, 3'b100, 32'h0000_3000, 32'h0,        32'h0,         0, 0, 2'b11, 32'h0,    4'b0000, 32'h0, 32'h0);
    run_op("shma",1, 3'b001, 32'h0000_7001, 32'h0,        32'h0,         0, 0, 2'b01, 32'h0,    4'b0000, 32'h0, 32'h0);
    check("err.ram", data_ram, 32'hFFFF_8FFF);
    run_op("swto",1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 32'h0,        -1, 1, 2'b00, 32'h4000, 4'b1111, 32'hCAFE_F00D, 32'h0);
    run_op("swlt",1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 32'h0,        15, 1, 2'b00, 32'h4000, 4'b1111, 32'hCAFE_F00D, 32'hFFFF_8FFF);
    run_op("lw0", 0, 3'b010, 32'h0000_0010, 32'h0,        32'h1111_1111, 0, 1, 2'b00, 32'h0010, 4'b0000, 32'h0, 32'h1111_1111);
    run_op("lw1", 0, 3'b010, 32'h0000_0014, 32'h0,        32'h2222_2222, 0, 1, 2'b00, 32'h0014, 4'b0000, 32'h0, 32'h2222_2222);
    check("b2b.ram", data_ram, 32'h2222_2222);

    // Reset in the middle of a bus transaction.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_8000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid.req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst.req", {29'd0, mem_req, done, err}, 32'd0);
    check("mrst.ready", 32'(req_ready), 32'd1);
    check("mrst.ram", data_ram, 32'd0);
    check("mrst.bus", mem_addr | mem_wdata | 32'(mem_wstrb) | 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (MaxWait + 4) @(posedge clk);
    #1;
    check("post.req", 32'(mem_req), 32'd0);
    check("sb.empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
